// File: rtl/pad_ser_pkg.sv
// rtl/pad_ser_pkg.sv - shared types, defaults and helpers for the pad sample serializer
package pad_ser_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } ser_state_e;

    localparam int DEF_DATA_W     = 12;
    localparam int DEF_FIFO_DEPTH = 4;
    localparam int DEF_SCLK_DIV   = 2;
    localparam int DEF_OVF_W      = 8;

    // Occupancy must represent 0..depth inclusive, hence one bit above the pointer width.
    function automatic int level_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with occupancy count and async active-low reset
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_push_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_pop_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_level;
    logic             w_push;
    logic             w_pop;

    // A full FIFO refuses pushes even when a pop frees a slot in the same cycle.
    assign w_push = i_push && !o_full;
    assign w_pop  = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    assign o_pop_data = r_mem[r_rd_ptr];
    assign o_full     = (r_level == (PTR_W+1)'(DEPTH));
    assign o_empty    = (r_level == '0);
    assign o_level    = r_level;

endmodule

// File: rtl/pad_sample_serializer.sv
// rtl/pad_sample_serializer.sv - buffers ADC samples and shifts them MSB-first onto the sclk/data/frame pads
module pad_sample_serializer
    import pad_ser_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int SCLK_DIV   = DEF_SCLK_DIV,
    parameter int OVF_W      = DEF_OVF_W
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             enable,
    input  logic [DATA_W-1:0]                in_data,
    input  logic                             in_valid,
    output logic                             in_ready,
    output logic                             ser_sclk,
    output logic                             ser_data,
    output logic                             ser_frame,
    output logic [2:0]                       ser_oe,
    output logic                             busy,
    output logic [level_w(FIFO_DEPTH)-1:0]   fifo_level,
    output logic [OVF_W-1:0]                 overflow_cnt
);

    localparam int DIV_W = $clog2(2 * SCLK_DIV);
    localparam int BIT_W = $clog2(DATA_W);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(SCLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(2 * SCLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

    ser_state_e        r_state, w_state_nx;
    logic [DIV_W-1:0]  r_div, w_div_nx;
    logic [BIT_W-1:0]  r_bit, w_bit_nx;
    logic [DATA_W-1:0] r_sr, w_sr_nx;
    logic [OVF_W-1:0]  r_ovf;
    logic              r_sclk, r_data, r_frame;
    logic [2:0]        r_oe;
    logic              w_pop, w_full, w_empty;
    logic [DATA_W-1:0] w_head;
    logic              w_sclk, w_data, w_frame;

    sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (in_valid),
        .i_push_data (in_data),
        .i_pop       (w_pop),
        .o_pop_data  (w_head),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_level     (fifo_level)
    );

    always_comb begin
        w_state_nx = r_state;
        w_div_nx   = r_div;
        w_bit_nx   = r_bit;
        w_sr_nx    = r_sr;
        w_pop      = 1'b0;
        case (r_state)
            IDLE: begin
                if (enable && !w_empty) begin
                    w_pop      = 1'b1;
                    w_sr_nx    = w_head;
                    w_bit_nx   = '0;
                    w_div_nx   = '0;
                    w_state_nx = SHIFT;
                end
            end
            SHIFT: begin
                if (r_div == DIV_LAST) begin
                    w_div_nx = '0;
                    w_sr_nx  = {r_sr[DATA_W-2:0], 1'b0};
                    if (r_bit == BIT_LAST) begin
                        w_state_nx = GAP;
                    end else begin
                        w_bit_nx = r_bit + 1'b1;
                    end
                end else begin
                    w_div_nx = r_div + 1'b1;
                end
            end
            GAP: begin
                if (r_div == DIV_LAST) begin
                    w_div_nx   = '0;
                    w_state_nx = IDLE;
                end else begin
                    w_div_nx = r_div + 1'b1;
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

    // Data only moves at bit boundaries, where the divider restarts with sclk low.
    assign w_frame = (r_state == SHIFT);
    assign w_data  = w_frame && r_sr[DATA_W-1];
    assign w_sclk  = w_frame && (r_div >= DIV_HALF);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_div   <= '0;
            r_bit   <= '0;
            r_sr    <= '0;
            r_ovf   <= '0;
            r_sclk  <= 1'b0;
            r_data  <= 1'b0;
            r_frame <= 1'b0;
            r_oe    <= 3'b000;
        end else begin
            r_state <= w_state_nx;
            r_div   <= w_div_nx;
            r_bit   <= w_bit_nx;
            r_sr    <= w_sr_nx;
            if (in_valid && w_full && !(&r_ovf)) begin
                r_ovf <= r_ovf + 1'b1;
            end
            r_sclk  <= w_sclk;
            r_data  <= w_data;
            r_frame <= w_frame;
            r_oe    <= {3{enable | busy}};
        end
    end

    assign in_ready     = !w_full;
    assign busy         = (r_state != IDLE);
    assign ser_sclk     = r_sclk;
    assign ser_data     = r_data;
    assign ser_frame    = r_frame;
    assign ser_oe       = r_oe;
    assign overflow_cnt = r_ovf;

endmodule

// File: tb/tb_pad_sample_serializer.sv
// tb/tb_pad_sample_serializer.sv - directed self-checking bench for pad_sample_serializer
module tb_pad_sample_serializer;

    localparam int DATA_W     = 12;
    localparam int FIFO_DEPTH = 4;
    localparam int SCLK_DIV   = 2;
    localparam int OVF_W      = 8;
    localparam int BIT_CYC    = 2 * SCLK_DIV;

    logic              clk      = 1'b0;
    logic              rst_n    = 1'b0;
    logic              enable   = 1'b1;
    logic [DATA_W-1:0] in_data  = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              ser_sclk, ser_data, ser_frame;
    logic [2:0]        ser_oe;
    logic              busy;
    logic [2:0]        fifo_level;
    logic [OVF_W-1:0]  overflow_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pad_sample_serializer #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH),
        .SCLK_DIV   (SCLK_DIV),
        .OVF_W      (OVF_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .ser_sclk     (ser_sclk),
        .ser_data     (ser_data),
        .ser_frame    (ser_frame),
        .ser_oe       (ser_oe),
        .busy         (busy),
        .fifo_level   (fifo_level),
        .overflow_cnt (overflow_cnt)
    );

    // Serial receiver: samples data on sclk rising edges, records words, frame and gap lengths.
    logic [DATA_W-1:0] rx_sr      = '0;
    int                rx_bits    = 0;
    int                flen       = 0;
    int                gcur       = 0;
    logic              prev_sclk  = 1'b0;
    logic              prev_frame = 1'b0;
    logic              seen       = 1'b0;
    logic [DATA_W-1:0] rx_q[$];
    int                len_q[$];
    int                nb_q[$];
    int                gap_q[$];

    always @(negedge clk) begin
        if (!rst_n) begin
            rx_sr = '0; rx_bits = 0; flen = 0; gcur = 0;
            prev_sclk = 1'b0; prev_frame = 1'b0; seen = 1'b0;
        end else begin
            if (ser_frame && !prev_frame) begin
                if (seen) gap_q.push_back(gcur);
                seen = 1'b1;
            end
            if (!ser_frame && prev_frame) begin
                rx_q.push_back(rx_sr);
                len_q.push_back(flen);
                nb_q.push_back(rx_bits);
                rx_sr = '0; rx_bits = 0; flen = 0; gcur = 0;
            end
            if (ser_frame) begin
                flen++;
                if (ser_sclk && !prev_sclk) begin
                    rx_sr = {rx_sr[DATA_W-2:0], ser_data};
                    rx_bits++;
                end
            end else begin
                gcur++;
            end
            prev_sclk  = ser_sclk;
            prev_frame = ser_frame;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_frames(input int n, input int budget);
        int c = 0;
        while (rx_q.size() < n && c < budget) begin
            tick();
            c++;
        end
        chk("frames_timeout", int'(rx_q.size() >= n), 1);
    endtask

    task automatic wait_idle(input int budget);
        int c = 0;
        while (busy && c < budget) begin
            tick();
            c++;
        end
        chk("idle_timeout", busy, 0);
    endtask

    task automatic push(input logic [DATA_W-1:0] d);
        in_data  = d;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    typedef struct {
        logic              valid;
        logic [DATA_W-1:0] data;
        logic              exp_ready;
        int                exp_level;
        int                exp_ovf;
    } vec_t;

    vec_t tbl[8];
    logic [DATA_W-1:0] b2b[4];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int rb;
        int gb;
        int c;

        tbl[0] = '{1'b1, 12'h111, 1'b1, 1, 0};
        tbl[1] = '{1'b1, 12'h222, 1'b1, 2, 0};
        tbl[2] = '{1'b1, 12'h333, 1'b1, 3, 0};
        tbl[3] = '{1'b1, 12'h444, 1'b0, 4, 0};
        tbl[4] = '{1'b1, 12'h555, 1'b0, 4, 1};
        tbl[5] = '{1'b1, 12'h666, 1'b0, 4, 2};
        tbl[6] = '{1'b0, 12'h777, 1'b0, 4, 2};
        tbl[7] = '{1'b0, 12'h888, 1'b0, 4, 2};
        b2b = '{12'h001, 12'h800, 12'hFFF, 12'h555};

        // Reset state, with enable already high
        #2;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_sclk", ser_sclk, 0);
        chk("rst_data", ser_data, 0);
        chk("rst_frame", ser_frame, 0);
        chk("rst_oe", ser_oe, 0);
        chk("rst_busy", busy, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_ovf", overflow_cnt, 0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        tick();

        // Single word: latency, content, frame length
        rb = rx_q.size();
        push(12'hA5C);
        chk("t1_level_after_push", fifo_level, 1);
        tick();
        chk("t1_frame_T1", ser_frame, 0);
        chk("t1_level_T1", fifo_level, 0);
        chk("t1_busy_T1", busy, 1);
        tick();
        chk("t1_frame_T2", ser_frame, 1);
        chk("t1_msb_T2", ser_data, 1);
        chk("t1_sclk_T2", ser_sclk, 0);
        wait_frames(rb + 1, 200);
        chk("t1_word", rx_q[rb], 12'hA5C);
        chk("t1_frame_len", len_q[rb], DATA_W * BIT_CYC);
        chk("t1_bits", nb_q[rb], DATA_W);
        wait_idle(20);
        chk("t1_oe_enabled", ser_oe, 3'b111);

        // Back-to-back: queue four words, then release them
        enable = 1'b0;
        for (int i = 0; i < 4; i++) push(b2b[i]);
        chk("t2_level_full", fifo_level, 4);
        chk("t2_ready_full", in_ready, 0);
        rb = rx_q.size();
        gb = gap_q.size();
        enable = 1'b1;
        wait_frames(rb + 4, 400);
        for (int i = 0; i < 4; i++) chk($sformatf("t2_word%0d", i), rx_q[rb + i], b2b[i]);
        for (int i = 1; i < 4; i++) chk($sformatf("t2_gap%0d", i), gap_q[gb + i], BIT_CYC + 1);
        wait_idle(20);
        chk("t2_level_drained", fifo_level, 0);

        // Enable dropped during bit 5 of the first of two queued words
        enable = 1'b0;
        push(12'h3C7);
        push(12'h9A1);
        rb = rx_q.size();
        enable = 1'b1;
        c = 0;
        while (!ser_frame && c < 10) begin
            tick();
            c++;
        end
        chk("t3_frame_start", ser_frame, 1);
        repeat (5 * BIT_CYC + 1) tick();
        enable = 1'b0;
        tick();
        chk("t3_oe_held", ser_oe, 3'b111);
        repeat (100) tick();
        chk("t3_one_frame", rx_q.size(), rb + 1);
        chk("t3_word0", rx_q[rb], 12'h3C7);
        chk("t3_level_kept", fifo_level, 1);
        chk("t3_busy", busy, 0);
        chk("t3_oe_off", ser_oe, 0);
        chk("t3_frame_low", ser_frame, 0);
        enable = 1'b1;
        wait_frames(rb + 2, 200);
        chk("t3_word1", rx_q[rb + 1], 12'h9A1);
        wait_idle(20);
        chk("t3_level_drained", fifo_level, 0);

        // Overflow table with enable low
        enable = 1'b0;
        tick();
        for (int i = 0; i < 8; i++) begin
            in_valid = tbl[i].valid;
            in_data  = tbl[i].data;
            tick();
            chk($sformatf("ovf_ready%0d", i), in_ready, tbl[i].exp_ready);
            chk($sformatf("ovf_level%0d", i), fifo_level, tbl[i].exp_level);
            chk($sformatf("ovf_cnt%0d", i), overflow_cnt, tbl[i].exp_ovf);
        end

        // Saturation, then a pop while full must still refuse the push
        in_valid = 1'b1;
        in_data  = 12'hBAD;
        repeat (300) tick();
        chk("sat_cnt", overflow_cnt, 255);
        tick();
        chk("sat_no_wrap", overflow_cnt, 255);
        chk("sat_level", fifo_level, 4);
        enable = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("full_pop_level", fifo_level, 3);
        chk("full_pop_ready", in_ready, 1);

        // Asynchronous reset during bit 7 of word 0x111
        tick();
        chk("rstm_frame_up", ser_frame, 1);
        repeat (7 * BIT_CYC + 1) tick();
        chk("rstm_frame_before", ser_frame, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rstm_sclk", ser_sclk, 0);
        chk("rstm_data", ser_data, 0);
        chk("rstm_frame", ser_frame, 0);
        chk("rstm_oe", ser_oe, 0);
        chk("rstm_busy", busy, 0);
        chk("rstm_level", fifo_level, 0);
        chk("rstm_ready", in_ready, 1);
        chk("rstm_ovf", overflow_cnt, 0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
        chk("post_rst_level", fifo_level, 0);
        chk("post_rst_ready", in_ready, 1);
        rb = rx_q.size();
        push(12'h6B2);
        wait_frames(rb + 1, 200);
        chk("post_rst_word", rx_q[rb], 12'h6B2);
        chk("post_rst_len", len_q[rb], DATA_W * BIT_CYC);
        wait_idle(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
